// File: rtl/pc_unit.sv
// Program-counter unit: conditional branches, jal/jalr, stall hold, trap/return FSM
// with EPC/cause capture, misaligned-target detection and a PC-advance counter.
module pc_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter logic [31:0]       TRAP_VECTOR  = 32'h0000_0080,
    parameter int                CNT_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        branch_op,
    input  logic              Zero,
    input  logic              Less,
    input  logic [XLEN-1:0]   Addr_result,
    input  logic [XLEN-1:0]   jalr_target,
    input  logic              trap_req,
    input  logic [3:0]        trap_cause,
    input  logic              eret,
    output logic [XLEN-1:0]   PC,
    output logic [XLEN-1:0]   branch_base_addr,
    output logic [XLEN-1:0]   link_addr,
    output logic [XLEN-1:0]   epc,
    output logic [3:0]        cause,
    output logic              in_handler,
    output logic              redirect,
    output logic [CNT_W-1:0]  adv_count
);

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] TRAP_PC  = XLEN'(TRAP_VECTOR);
    localparam logic [3:0]      CAUSE_MA = 4'hF;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   r_epc;
    logic [XLEN-1:0]   w_epc_nxt;
    logic [3:0]        r_cause;
    logic [3:0]        w_cause_nxt;
    logic              r_redirect;
    logic              w_redirect_nxt;
    logic [CNT_W-1:0]  r_adv;
    logic              w_taken;
    logic              w_misaligned;
    logic [XLEN-1:0]   w_target;
    logic [XLEN-1:0]   w_pc_seq;

    assign w_pc_seq = r_pc + PC_STEP;

    // Branch resolution; reserved op 7 decodes as not taken.
    always_comb begin
        w_taken  = 1'b0;
        w_target = Addr_result;
        case (branch_op)
            3'd1:    w_taken = Zero;
            3'd2:    w_taken = ~Zero;
            3'd3:    w_taken = Less;
            3'd4:    w_taken = ~Less;
            3'd5:    w_taken = 1'b1;
            3'd6: begin
                w_taken  = 1'b1;
                w_target = {jalr_target[XLEN-1:1], 1'b0};
            end
            default: w_taken = 1'b0;
        endcase
        w_misaligned = w_taken & (w_target[1:0] != 2'b00);
    end

    // Next-state / next-PC selection for the RUN/HANDLER FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_epc_nxt      = r_epc;
        w_cause_nxt    = r_cause;
        w_redirect_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                // eret has no effect here and simply falls through.
                if (trap_req || w_misaligned) begin
                    w_epc_nxt      = r_pc;
                    w_cause_nxt    = trap_req ? trap_cause : CAUSE_MA;
                    w_pc_nxt       = TRAP_PC;
                    w_state_nxt    = ST_HANDLER;
                    w_redirect_nxt = 1'b1;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_taken) begin
                    w_pc_nxt       = w_target;
                    w_redirect_nxt = 1'b1;
                end else begin
                    w_pc_nxt = w_pc_seq;
                end
            end
            ST_HANDLER: begin
                // No nesting: trap_req is ignored and epc/cause are preserved.
                if (w_misaligned) begin
                    w_pc_nxt       = TRAP_PC;
                    w_redirect_nxt = 1'b1;
                end else if (eret && !stall) begin
                    w_pc_nxt       = r_epc + PC_STEP;
                    w_state_nxt    = ST_RUN;
                    w_redirect_nxt = 1'b1;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_taken) begin
                    w_pc_nxt       = w_target;
                    w_redirect_nxt = 1'b1;
                end else begin
                    w_pc_nxt = w_pc_seq;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_pc_nxt    = RESET_VECTOR;
            end
        endcase
    end

    // State, PC and trap-context registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_cause    <= 4'h0;
            r_redirect <= 1'b0;
            r_adv      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_epc      <= w_epc_nxt;
            r_cause    <= w_cause_nxt;
            r_redirect <= w_redirect_nxt;
            if (w_pc_nxt != r_pc) begin
                r_adv <= r_adv + CNT_W'(1);
            end else begin
                r_adv <= r_adv;
            end
        end
    end

    assign PC               = r_pc;
    assign branch_base_addr = r_pc;
    assign link_addr        = w_pc_seq;
    assign epc              = r_epc;
    assign cause            = r_cause;
    assign in_handler       = (r_state == ST_HANDLER);
    assign redirect         = r_redirect;
    assign adv_count        = r_adv;

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit plus hand sequences for wrap and mid-handler reset.
module tb_pc_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  branch_op;
    logic        Zero, Less;
    logic [31:0] Addr_result, jalr_target;
    logic        trap_req;
    logic [3:0]  trap_cause;
    logic        eret;
    logic [31:0] PC, branch_base_addr, link_addr, epc, adv_count;
    logic [3:0]  cause;
    logic        in_handler, redirect;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    pc_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .branch_op(branch_op),
        .Zero(Zero), .Less(Less), .Addr_result(Addr_result), .jalr_target(jalr_target),
        .trap_req(trap_req), .trap_cause(trap_cause), .eret(eret),
        .PC(PC), .branch_base_addr(branch_base_addr), .link_addr(link_addr),
        .epc(epc), .cause(cause), .in_handler(in_handler), .redirect(redirect),
        .adv_count(adv_count)
    );

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic        z;
        logic        l;
        logic [31:0] addr;
        logic [31:0] jt;
        logic        trq;
        logic [3:0]  tc;
        logic        er;
        logic [31:0] e_pc;
        logic        e_rd;
        logic        e_ih;
        logic [31:0] e_epc;
        logic [3:0]  e_cause;
        logic [31:0] e_adv;
    } vec_t;

    vec_t vecs [0:31];

    function automatic vec_t mk(logic st, logic [2:0] op, logic z, logic l,
                                logic [31:0] addr, logic [31:0] jt, logic trq,
                                logic [3:0] tc, logic er, logic [31:0] e_pc,
                                logic e_rd, logic e_ih, logic [31:0] e_epc,
                                logic [3:0] e_cause, logic [31:0] e_adv);
        vec_t v;
        v.st = st; v.op = op; v.z = z; v.l = l; v.addr = addr; v.jt = jt;
        v.trq = trq; v.tc = tc; v.er = er; v.e_pc = e_pc; v.e_rd = e_rd;
        v.e_ih = e_ih; v.e_epc = e_epc; v.e_cause = e_cause; v.e_adv = e_adv;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.st; branch_op = v.op; Zero = v.z; Less = v.l;
        Addr_result = v.addr; jalr_target = v.jt; trap_req = v.trq;
        trap_cause = v.tc; eret = v.er;
    endtask

    task automatic check_state(input int idx, input vec_t v);
        chk("pc", idx, PC, v.e_pc);
        chk("redirect", idx, {31'd0, redirect}, {31'd0, v.e_rd});
        chk("in_handler", idx, {31'd0, in_handler}, {31'd0, v.e_ih});
        chk("epc", idx, epc, v.e_epc);
        chk("cause", idx, {28'd0, cause}, {28'd0, v.e_cause});
        chk("adv_count", idx, adv_count, v.e_adv);
    endtask

    logic [31:0] prev_pc;
    vec_t        v;

    initial begin
        // st op z l addr jt trq tc er | pc rd ih epc cause adv
        vecs[0]  = mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h04,0,0,32'h00,4'h0,32'd1);
        vecs[1]  = mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h08,0,0,32'h00,4'h0,32'd2);
        vecs[2]  = mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h0C,0,0,32'h00,4'h0,32'd3);
        vecs[3]  = mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h10,0,0,32'h00,4'h0,32'd4);
        vecs[4]  = mk(0,1,1,0,32'h40,32'h0,0,4'h0,0, 32'h40,1,0,32'h00,4'h0,32'd5);
        vecs[5]  = mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h44,0,0,32'h00,4'h0,32'd6);
        vecs[6]  = mk(0,5,0,0,32'h10,32'h0,0,4'h0,0, 32'h10,1,0,32'h00,4'h0,32'd7);
        vecs[7]  = mk(0,2,1,0,32'h40,32'h0,0,4'h0,0, 32'h14,0,0,32'h00,4'h0,32'd8);
        vecs[8]  = mk(0,3,0,1,32'h20,32'h0,0,4'h0,0, 32'h20,1,0,32'h00,4'h0,32'd9);
        vecs[9]  = mk(0,6,0,0,32'h0,32'h31,0,4'h0,0, 32'h30,1,0,32'h00,4'h0,32'd10);
        vecs[10] = mk(0,5,0,0,32'h42,32'h0,0,4'h0,0, 32'h80,1,1,32'h30,4'hF,32'd11);
        vecs[11] = mk(0,0,0,0,32'h0,32'h0,0,4'h0,1, 32'h34,1,0,32'h30,4'hF,32'd12);
        vecs[12] = mk(0,4,0,0,32'h50,32'h0,0,4'h0,0, 32'h50,1,0,32'h30,4'hF,32'd13);
        vecs[13] = mk(1,0,0,0,32'h0,32'h0,1,4'h3,0, 32'h80,1,1,32'h50,4'h3,32'd14);
        vecs[14] = mk(0,0,0,0,32'h0,32'h0,1,4'h5,0, 32'h84,0,1,32'h50,4'h3,32'd15);
        vecs[15] = mk(1,0,0,0,32'h0,32'h0,0,4'h0,1, 32'h84,0,1,32'h50,4'h3,32'd15);
        vecs[16] = mk(0,0,0,0,32'h0,32'h0,0,4'h0,1, 32'h54,1,0,32'h50,4'h3,32'd16);
        vecs[17] = mk(0,0,0,0,32'h0,32'h0,1,4'h2,0, 32'h80,1,1,32'h54,4'h2,32'd17);
        vecs[18] = mk(0,5,0,0,32'h102,32'h0,0,4'h0,0, 32'h80,1,1,32'h54,4'h2,32'd17);
        vecs[19] = mk(0,0,0,0,32'h0,32'h0,0,4'h0,1, 32'h58,1,0,32'h54,4'h2,32'd18);
        vecs[20] = mk(0,5,0,0,32'h08,32'h0,0,4'h0,0, 32'h08,1,0,32'h54,4'h2,32'd19);
        vecs[21] = mk(1,1,1,0,32'h40,32'h0,0,4'h0,0, 32'h08,0,0,32'h54,4'h2,32'd19);
        vecs[22] = mk(1,1,1,0,32'h40,32'h0,0,4'h0,0, 32'h08,0,0,32'h54,4'h2,32'd19);
        vecs[23] = mk(1,1,1,0,32'h40,32'h0,0,4'h0,0, 32'h08,0,0,32'h54,4'h2,32'd19);
        vecs[24] = mk(1,1,1,0,32'h40,32'h0,0,4'h0,0, 32'h08,0,0,32'h54,4'h2,32'd19);
        vecs[25] = mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h0C,0,0,32'h54,4'h2,32'd20);
        vecs[26] = mk(0,0,0,0,32'h0,32'h0,0,4'h0,1, 32'h10,0,0,32'h54,4'h2,32'd21);
        vecs[27] = mk(0,5,0,0,32'h10,32'h0,0,4'h0,0, 32'h10,1,0,32'h54,4'h2,32'd21);
        vecs[28] = mk(0,7,1,0,32'h40,32'h0,0,4'h0,0, 32'h14,0,0,32'h54,4'h2,32'd22);
        vecs[29] = mk(0,3,0,0,32'h40,32'h0,0,4'h0,0, 32'h18,0,0,32'h54,4'h2,32'd23);
        vecs[30] = mk(0,5,0,0,32'h42,32'h0,1,4'h6,0, 32'h80,1,1,32'h18,4'h6,32'd24);
        vecs[31] = mk(0,0,0,0,32'h0,32'h0,0,4'h0,1, 32'h1C,1,0,32'h18,4'h6,32'd25);

        reset = 1'b1;
        drive(mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h0,0,0,32'h0,4'h0,32'd0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_state(-1, mk(0,0,0,0,0,0,0,0,0, 32'h0,0,0,32'h0,4'h0,32'd0));
        prev_pc = 32'h0;

        for (int i = 0; i < 32; i++) begin
            drive(vecs[i]);
            #1;
            chk("branch_base_addr", i, branch_base_addr, prev_pc);
            chk("link_addr", i, link_addr, prev_pc + 32'd4);
            @(posedge clock);
            #1;
            check_state(i, vecs[i]);
            prev_pc = vecs[i].e_pc;
        end

        // Wrap from the top of the address space, then reset from inside the handler.
        v = mk(0,5,0,0,32'hFFFF_FFFC,32'h0,0,4'h0,0, 32'hFFFF_FFFC,1,0,32'h18,4'h6,32'd26);
        drive(v); @(posedge clock); #1; check_state(100, v);
        v = mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h0,0,0,32'h18,4'h6,32'd27);
        drive(v); @(posedge clock); #1; check_state(101, v);
        v = mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h4,0,0,32'h18,4'h6,32'd28);
        drive(v); @(posedge clock); #1; check_state(102, v);
        v = mk(0,0,0,0,32'h0,32'h0,1,4'h7,0, 32'h80,1,1,32'h4,4'h7,32'd29);
        drive(v); @(posedge clock); #1; check_state(103, v);
        reset = 1'b1;
        v = mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h0,0,0,32'h0,4'h0,32'd0);
        drive(v); @(posedge clock); #1; check_state(104, v);
        reset = 1'b0;
        v = mk(0,0,0,0,32'h0,32'h0,0,4'h0,0, 32'h4,0,0,32'h0,4'h0,32'd1);
        drive(v); @(posedge clock); #1; check_state(105, v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle core. It replaces the beq-only PC. It adds:
- full conditional-branch decode (beq/bne/blt/bge) and unconditional jumps (jal/jalr);
- a pipeline-style stall hold;
- a two-state trap/return FSM with EPC and cause capture;
- misaligned-target detection;
- an advance counter.

It sits between the controller/ALU and instruction memory, and drives the fetch address every cycle.

Parameters:
XLEN, 32, width of PC and all address ports
RESET_VECTOR, 0, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0080, handler entry address (low XLEN bits used)
CNT_W, 32, width of the advance counter

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC this cycle
branch_op  in  3  0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 jal, 6 jalr, 7 reserved (treated as none)
Zero  in  1  ALU equality flag
Less  in  1  ALU signed less-than flag
Addr_result  in  XLEN  branch/jal target from ALU
jalr_target  in  XLEN  rs1+imm from ALU; bit 0 is cleared before use
trap_req  in  1  external/illegal-instruction trap request
trap_cause  in  4  cause code accompanying trap_req
eret  in  1  return from handler
PC  out  XLEN  current fetch address
branch_base_addr  out  XLEN  equals PC (combinational)
link_addr  out  XLEN  PC+4 (combinational), written to rd on jal/jalr
epc  out  XLEN  saved PC of the trapping instruction
cause  out  4  latched trap cause; 4'hF = misaligned target
in_handler  out  1  FSM state is HANDLER
redirect  out  1  registered, high for one cycle after any non-sequential PC update
adv_count  out  CNT_W  number of cycles in which PC changed

Behaviour:
- Reset (sync, highest priority):
  - PC=RESET_VECTOR; epc=0; cause=0; state=RUN; redirect=0; adv_count=0.
  - Reset asserted mid-handler discards the handler state.
- Branch condition:
  - taken = (beq & Zero) | (bne & ~Zero) | (blt & Less) | (bge & ~Less) | jal | jalr.
  - target = jalr ? {jalr_target[XLEN-1:1],1'b0} : Addr_result.
- Misaligned: taken & target[1:0]!=0 is treated as an internal trap with cause=4'hF.
- Priority, evaluated per rising edge in RUN, first match wins:
  1. trap_req or misaligned: epc<=PC; cause<=trap_cause (or 4'hF); PC<=TRAP_VECTOR; state<=HANDLER; redirect<=1.
     - trap_req beats misaligned; cause is then trap_cause.
     - Traps ignore stall.
  2. eret in RUN: ignored (treated as no-op); evaluation falls through to the lower items.
  3. stall: PC holds; redirect<=0; a pending branch is dropped (the controller re-presents it).
  4. taken: PC<=target; redirect<=1.
  5. otherwise: PC<=PC+4; redirect<=0.
- In HANDLER:
  - trap_req is ignored (no nesting).
  - A misaligned target still forces PC<=TRAP_VECTOR, but epc and cause are not overwritten.
  - eret (unless stall): PC<=epc+4; state<=RUN; redirect<=1.
  - eret with stall: held until a non-stalled cycle.
  - Otherwise branches, stalls and sequential updates behave as in RUN.
- Arithmetic:
  - All additions are modulo 2^XLEN; PC=max-3 wraps to 0 silently.
  - adv_count increments by 1 on every non-reset edge where the new PC differs from the old PC, and wraps at 2^CNT_W.
  - A branch to its own address does not count.
- No combinational path from trap_req/eret to PC; PC is purely registered.

Test Plan:
1. Reset then 3 idle cycles -> PC 0,4,8,12; adv_count=3; redirect=0.
2. PC=0x10, branch_op=1, Zero=1, Addr_result=0x40 -> PC=0x40, redirect=1 for one cycle. Repeat with branch_op=2, Zero=1 -> PC=0x14.
3. PC=0x20, branch_op=6, jalr_target=0x31 -> PC=0x30, link_addr observed 0x24 before the edge. Then branch_op=5, Addr_result=0x42 -> PC=TRAP_VECTOR, cause=F, epc=0x30.
4. PC=0x50, trap_req=1, trap_cause=3, stall=1 -> PC=0x80, epc=0x50, in_handler=1. A second trap_req inside the handler changes nothing. eret -> PC=0x54, in_handler=0.
5. stall held 4 cycles at PC=0x8 with branch_op=1, Zero=1 -> PC stays 0x8, adv_count unchanged. Release with branch_op=0 -> 0xC.
6. PC=0xFFFF_FFFC sequential -> PC=0; reset asserted inside the handler -> PC=0, in_handler=0, epc=0.
